md_issue_ctrl: RTL
==================

// Module: md_issue_ctrl
// PURPOSE
//  E-stage sequencer for the multiply/divide unit. Issues mult/multu/div/divu/mthi/mtlo to the MDU.
//  Counts out the fixed operation latency and pulses a HI/LO commit strobe.
//  Stalls the D stage while any HI/LO-class instruction there would collide with an in-flight op.
// PARAMETERS
//  MULT_LAT  5   busy cycles for mult/multu, start cycle included; must be >= 2
//  DIV_LAT   10  busy cycles for div/divu, start cycle included; must be >= 2
//  CNT_W     4   counter width; must hold max(MULT_LAT, DIV_LAT)
// PORTS
//  clk        in   1   clock, all state updates on posedge
//  reset      in   1   synchronous, active-high
//  d_md_op    in   4   MD op code of instruction in D stage (0 = none)
//  e_valid    in   1   E-stage instruction valid (not a bubble)
//  e_md_op    in   4   MD op code of instruction in E stage
//  cancel     in   1   abort in-flight op (honoured only with MD_CANCEL_EN)
//  start_o    out  1   one-cycle MDU start pulse
//  op_o       out  4   op code driven to MDU control input
//  busy_o     out  1   MDU occupied
//  commit_o   out  1   one-cycle pulse: MDU result valid, write HI/LO
//  stall_o    out  1   freeze PC/F/D and insert bubble into E
//  err_o      out  1   sticky: E-stage MD op arrived while busy (hazard-logic bug)
// BEHAVIOUR
//  - Op codes: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mfhi, 6 mflo, 7 mthi, 8 mtlo; 9-15 are treated as none.
//  - Reset: state=IDLE, cnt=0, err_o=0, all outputs 0, op_o=0.
//  - FSM has two states, IDLE and RUN.
//  - IDLE, when e_valid and e_md_op in 1..4:
//    - start_o=1 and op_o=e_md_op (combinational, same cycle).
//    - cnt loads LAT-1, using MULT_LAT for 1/2 and DIV_LAT for 3/4.
//    - Next state is RUN.
//  - IDLE, when e_valid and e_md_op in 7/8: op_o=e_md_op and start_o=0; stay IDLE (MDU writes HI/LO directly).
//  - IDLE, e_md_op 5/6 or no valid op: op_o=0 and start_o=0.
//  - RUN: cnt decrements every cycle and op_o=0.
//    - At cnt==1, commit_o=1 and next state is IDLE.
//  - Latency: start at cycle T, commit_o at T+LAT-1, busy_o high exactly on T..T+LAT-1.
//    - A dependent D-stage op issues in E at T+LAT.
//  - busy_o = start_o | (state==RUN).
//  - stall_o = busy_o & (d_md_op in 1..8). All eight op classes stall; non-MD ops flow freely.
//  - Any E-stage op in 1..8 while in RUN is ignored (no restart, cnt unchanged) and sets err_o.
//    - err_o is cleared only by reset.
//  - Back-to-back ops: the second MD op reaches E at the earliest at T+LAT, when the FSM is in IDLE, and starts normally.
//  - Reset mid-RUN: the FSM returns to IDLE next cycle with no commit_o pulse.
//  - e_valid=0 suppresses all issue regardless of e_md_op.
// CONFIGURATION
//  MD_CANCEL_EN defined:
//    - cancel=1 in RUN forces IDLE next cycle with cnt=0 and no commit_o; cancel wins over cnt==1.
//    - cancel=1 in IDLE gates start_o and op_o to 0; no state change.
//  MD_CANCEL_EN undefined:
//    - The cancel port exists but is ignored; no added logic.
// TESTING
//  1. reset=1 for 2 cycles, then idle: all outputs 0 and err_o=0.
//  2. mult at T (e_valid=1, e_md_op=1):
//     - start_o=1 and op_o=1 at T.
//     - busy_o high on T..T+4.
//     - commit_o only at T+4.
//  3. divu at T with d_md_op=6 (mflo) behind it:
//     - stall_o high T..T+9.
//     - commit_o at T+9; stall_o=0 at T+10.
//  4. mthi (op 7) in IDLE: op_o=7, start_o=0, busy_o=0. Non-MD D op during mult busy: stall_o=0.
//  5. Force e_md_op=3 while RUN after mult: ignored, commit_o still at T+4, err_o=1 until reset.
//  6. MD_CANCEL_EN, cancel at T+2 of div:
//     - IDLE at T+3 and commit_o never pulses.
//     - Without the macro, commit_o occurs at T+9.

Source files
------------

// File: rtl/md_issue_ctrl.sv
// E-stage issue/latency sequencer for the multiply/divide unit, with HI/LO hazard stall.
// Optional cancel support is enabled by defining MD_CANCEL_EN.
module md_issue_ctrl #(
  parameter int unsigned MULT_LAT = 5,
  parameter int unsigned DIV_LAT  = 10,
  parameter int unsigned CNT_W    = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] d_md_op,
  input  logic       e_valid,
  input  logic [3:0] e_md_op,
  input  logic       cancel,
  output logic       start_o,
  output logic [3:0] op_o,
  output logic       busy_o,
  output logic       commit_o,
  output logic       stall_o,
  output logic       err_o
);

  localparam logic [CNT_W-1:0] MultLoad = CNT_W'(MULT_LAT - 1);
  localparam logic [CNT_W-1:0] DivLoad  = CNT_W'(DIV_LAT - 1);
  localparam logic [CNT_W-1:0] CntOne   = CNT_W'(1);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             err_q;

  logic e_mul, e_div, e_mt, e_any, d_any, is_idle, cancel_act;

  assign e_mul = e_valid && (e_md_op == 4'd1 || e_md_op == 4'd2);
  assign e_div = e_valid && (e_md_op == 4'd3 || e_md_op == 4'd4);
  assign e_mt  = e_valid && (e_md_op == 4'd7 || e_md_op == 4'd8);
  assign e_any = e_valid && (e_md_op >= 4'd1) && (e_md_op <= 4'd8);
  assign d_any = (d_md_op >= 4'd1) && (d_md_op <= 4'd8);

`ifdef MD_CANCEL_EN
  assign cancel_act = cancel;
`else
  logic unused_cancel;
  assign unused_cancel = cancel;
  assign cancel_act    = 1'b0;
`endif

  assign is_idle  = (state_q == StIdle);
  assign start_o  = is_idle && (e_mul || e_div) && !cancel_act;
  assign op_o     = (is_idle && (e_mul || e_div || e_mt) && !cancel_act) ? e_md_op : 4'd0;
  assign busy_o   = start_o || !is_idle;
  // Cancel takes priority over the final count so an aborted op never commits.
  assign commit_o = !is_idle && (cnt_q == CntOne) && !cancel_act;
  assign stall_o  = busy_o && d_any;
  assign err_o    = err_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start_o) begin
            cnt_q   <= e_mul ? MultLoad : DivLoad;
            state_q <= StRun;
          end
        end
        StRun: begin
          // Ops reaching E while busy mean the D-stage stall failed; flag, never restart.
          if (e_any) begin
            err_q <= 1'b1;
          end
          if (cancel_act) begin
            cnt_q   <= '0;
            state_q <= StIdle;
          end else begin
            cnt_q <= cnt_q - CntOne;
            if (cnt_q == CntOne) begin
              state_q <= StIdle;
            end
          end
        end
        default: begin
          state_q <= StIdle;
          cnt_q   <= '0;
        end
      endcase
    end
  end

endmodule
